// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit
// Multi-cycle multiply/divide unit living in the E stage of the 5-stage MIPS
// pipeline. It owns the architectural HI/LO registers and raises `busy` so the
// hazard unit can hold HI/LO-touching instructions in D until a result lands.
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous reset, active-low
//   start  MD instruction valid in E this cycle (qualifies md_op)
//   md_op  1=mult 2=multu 3=div 4=divu 5=mthi 6=mtlo 7=madd 0=none
//   a, b   forwarded rs / rt operands, sampled only on the start edge
//   busy   registered: a multi-cycle operation is in flight
//   hi,lo  HI and LO registers
//
// Parameters
//   MULT_CYCLES  busy cycles for mult/multu/madd (>= 1)
//   DIV_CYCLES   busy cycles for div/divu (>= 1)
//
// Optional feature macro: MD_MADD_EN
//   Defined   -> md_op=7 accumulates signed(a)*signed(b) into {hi,lo}.
//   Undefined -> md_op=7 is a no-op and no accumulator adder exists.
// ---------------------------------------------------------------------------
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [31:0] counter;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_write;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_zero;
    logic        div_ovf;
    logic [31:0] safe_bs;
    logic [31:0] safe_bu;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic [31:0] quot_u;
    logic [31:0] rem_u;

    logic [63:0] op_res;
    logic        op_write;
    logic        op_multi;
    logic [31:0] op_cycles;

    // Full-width products: sign- or zero-extend to 64 bits so the low 64
    // bits of the product are exact for both flavours.
    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // The divider never sees a zero divisor or the one overflowing signed
    // case; both are replaced by 1 and their results are fixed up or dropped.
    assign div_zero = (b == 32'd0);
    assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign safe_bs  = (div_zero || div_ovf) ? 32'd1 : b;
    assign safe_bu  = div_zero ? 32'd1 : b;
    assign quot_s   = div_ovf ? 32'sh8000_0000 : ($signed(a) / $signed(safe_bs));
    assign rem_s    = div_ovf ? 32'sd0 : ($signed(a) % $signed(safe_bs));
    assign quot_u   = a / safe_bu;
    assign rem_u    = a % safe_bu;

`ifdef MD_MADD_EN
    logic [63:0] acc_sum;
    assign acc_sum = {hi, lo} + prod_s;
`endif

    // Decode md_op into the pending result, whether it will be committed,
    // and how many cycles the unit stays busy.
    always_comb begin
        op_res    = 64'd0;
        op_write  = 1'b0;
        op_multi  = 1'b0;
        op_cycles = 32'd0;
        case (md_op)
            3'd1: begin
                op_res    = prod_s;
                op_write  = 1'b1;
                op_multi  = 1'b1;
                op_cycles = 32'(MULT_CYCLES);
            end
            3'd2: begin
                op_res    = prod_u;
                op_write  = 1'b1;
                op_multi  = 1'b1;
                op_cycles = 32'(MULT_CYCLES);
            end
            3'd3: begin
                op_res    = {rem_s, quot_s};
                op_write  = !div_zero;
                op_multi  = 1'b1;
                op_cycles = 32'(DIV_CYCLES);
            end
            3'd4: begin
                op_res    = {rem_u, quot_u};
                op_write  = !div_zero;
                op_multi  = 1'b1;
                op_cycles = 32'(DIV_CYCLES);
            end
`ifdef MD_MADD_EN
            3'd7: begin
                op_res    = acc_sum;
                op_write  = 1'b1;
                op_multi  = 1'b1;
                op_cycles = 32'(MULT_CYCLES);
            end
`endif
            default: ;
        endcase
    end

    // Control FSM: the result is computed at the start edge and parked in
    // res_hi/res_lo; HI/LO only change on the final countdown edge, so they
    // hold their old values for the whole RUN phase. A start seen in RUN is
    // ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            hi        <= 32'd0;
            lo        <= 32'd0;
            counter   <= 32'd0;
            res_hi    <= 32'd0;
            res_lo    <= 32'd0;
            res_write <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op_multi) begin
                            res_hi    <= op_res[63:32];
                            res_lo    <= op_res[31:0];
                            res_write <= op_write;
                            counter   <= op_cycles;
                            busy      <= 1'b1;
                            state     <= RUN;
                        end else if (md_op == 3'd5) begin
                            hi <= a;
                        end else if (md_op == 3'd6) begin
                            lo <= a;
                        end
                    end
                end
                RUN: begin
                    counter <= counter - 32'd1;
                    if (counter == 32'd1) begin
                        if (res_write) begin
                            hi <= res_hi;
                            lo <= res_lo;
                        end
                        busy      <= 1'b0;
                        res_write <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// ---------------------------------------------------------------------------
// tb_md_unit
// Self-checking bench for md_unit. A cycle-level reference model of the
// architectural behaviour (HI/LO contents and busy window length) runs beside
// the DUT and is compared every negative clock edge; directed vectors with
// hand-computed literals pin the model itself.
// ---------------------------------------------------------------------------
module tb_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int passes = 0;
    int n;

    logic [31:0] m_hi;
    logic [31:0] m_lo;
    int          m_left;
    logic [63:0] m_pend;
    logic        m_write;

    always #5 clk = ~clk;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .md_op (md_op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // 64-bit product from plain integer arithmetic.
    function automatic logic [63:0] mulModel(input bit sgn, input logic [31:0] x, input logic [31:0] y);
        if (sgn) return longint'($signed(x)) * longint'($signed(y));
        return {32'd0, x} * {32'd0, y};
    endfunction

    // {remainder, quotient}; caller guarantees y != 0.
    function automatic logic [63:0] divModel(input bit sgn, input logic [31:0] x, input logic [31:0] y);
        int q;
        int r;
        if (sgn) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            q = int'(x) / int'(y);
            r = int'(x) % int'(y);
            return {r, q};
        end
        return {x % y, x / y};
    endfunction

    // Reference model: cycles-remaining counter plus pending 64-bit result.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi    <= 32'd0;
            m_lo    <= 32'd0;
            m_left  <= 0;
            m_pend  <= 64'd0;
            m_write <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1 && m_write) begin
                m_hi <= m_pend[63:32];
                m_lo <= m_pend[31:0];
            end
        end else if (start) begin
            case (md_op)
                3'd1: begin m_pend <= mulModel(1'b1, a, b); m_write <= 1'b1; m_left <= MC; end
                3'd2: begin m_pend <= mulModel(1'b0, a, b); m_write <= 1'b1; m_left <= MC; end
                3'd3: begin
                    m_write <= (b != 0);
                    m_left  <= DC;
                    if (b != 0) m_pend <= divModel(1'b1, a, b);
                end
                3'd4: begin
                    m_write <= (b != 0);
                    m_left  <= DC;
                    if (b != 0) m_pend <= divModel(1'b0, a, b);
                end
                3'd5: m_hi <= a;
                3'd6: m_lo <= a;
`ifdef MD_MADD_EN
                3'd7: begin m_pend <= {m_hi, m_lo} + mulModel(1'b1, a, b); m_write <= 1'b1; m_left <= MC; end
`endif
                default: ;
            endcase
        end
    end

    // Per-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("cyc_busy", 32'(busy), 32'(m_left > 0));
            checkOutput("cyc_hi", hi, m_hi);
            checkOutput("cyc_lo", lo, m_lo);
        end
    end

    // Present one operation for exactly one clock edge, then scramble the
    // operands so any late sampling by the DUT shows up.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        md_op = op;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        md_op = 3'd0;
        a     = $urandom;
        b     = $urandom;
    endtask

    // Count negedges with busy high, bounded.
    task automatic waitIdle(output int cnt);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
        end
    endtask

    task automatic checkZero(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_hi"}, hi, 32'd0);
        checkOutput({tag, "_lo"}, lo, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        md_op = 3'd0;
        a     = 32'd0;
        b     = 32'd0;

        // Asynchronous reset in the middle of a cycle.
        #2 rst_n = 1'b0;
        #1 checkZero("rst_async");
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 checkZero("rst_release");

        // mult / multu
        applyStimulus(3'd1, 32'hFFFF_FFFE, 32'd3);
        waitIdle(n);
        checkOutput("mult_busy_cycles", n, 32'd5);
        checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
        checkOutput("mult_lo", lo, 32'hFFFF_FFFA);
        applyStimulus(3'd2, 32'hFFFF_FFFE, 32'd3);
        waitIdle(n);
        checkOutput("multu_busy_cycles", n, 32'd5);
        checkOutput("multu_hi", hi, 32'h0000_0002);
        checkOutput("multu_lo", lo, 32'hFFFF_FFFA);

        // div / divu
        applyStimulus(3'd3, 32'hFFFF_FFF9, 32'd2);
        waitIdle(n);
        checkOutput("div_busy_cycles", n, 32'd10);
        checkOutput("div_lo", lo, 32'hFFFF_FFFD);
        checkOutput("div_hi", hi, 32'hFFFF_FFFF);
        applyStimulus(3'd4, 32'd7, 32'd2);
        waitIdle(n);
        checkOutput("divu_lo", lo, 32'd3);
        checkOutput("divu_hi", hi, 32'd1);

        // Divide by zero keeps HI/LO
        applyStimulus(3'd5, 32'h11, 32'd0);
        checkOutput("mthi_busy", 32'(busy), 32'd0);
        checkOutput("mthi_hi", hi, 32'h11);
        applyStimulus(3'd6, 32'h22, 32'd0);
        checkOutput("mtlo_lo", lo, 32'h22);
        applyStimulus(3'd4, 32'd1234, 32'd0);
        waitIdle(n);
        checkOutput("div0_busy_cycles", n, 32'd10);
        checkOutput("div0_hi", hi, 32'h11);
        checkOutput("div0_lo", lo, 32'h22);
        applyStimulus(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        waitIdle(n);
        checkOutput("divovf_lo", lo, 32'h8000_0000);
        checkOutput("divovf_hi", hi, 32'h0);

        // mthi, then a start while busy must be ignored
        applyStimulus(3'd5, 32'hDEAD_BEEF, 32'd0);
        checkOutput("mthi2_hi", hi, 32'hDEAD_BEEF);
        checkOutput("mthi2_busy", 32'(busy), 32'd0);
        applyStimulus(3'd3, 32'd100, 32'd7);
        @(negedge clk);
        checkOutput("busy_hold_hi", hi, 32'hDEAD_BEEF);
        applyStimulus(3'd1, 32'd5, 32'd5);
        waitIdle(n);
        checkOutput("ignored_lo", lo, 32'd14);
        checkOutput("ignored_hi", hi, 32'd2);
        repeat (MC + 2) @(negedge clk);
        checkOutput("ignored_after_busy", 32'(busy), 32'd0);
        checkOutput("ignored_after_lo", lo, 32'd14);

        // madd (or no-op when the feature is absent)
        applyStimulus(3'd5, 32'd0, 32'd0);
        applyStimulus(3'd6, 32'd10, 32'd0);
        applyStimulus(3'd7, 32'd3, 32'd4);
        waitIdle(n);
`ifdef MD_MADD_EN
        checkOutput("madd_busy_cycles", n, 32'd5);
        checkOutput("madd_lo", lo, 32'd22);
`else
        checkOutput("madd_busy_cycles", n, 32'd0);
        checkOutput("madd_lo", lo, 32'd10);
`endif
        checkOutput("madd_hi", hi, 32'd0);

        // Reset two cycles into a div aborts it
        applyStimulus(3'd4, 32'd1000, 32'd3);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 checkZero("rst_div");
        #1 rst_n = 1'b1;
        #1 checkZero("rst_div_release");
        repeat (DC + 2) @(negedge clk);
        checkZero("rst_div_after");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
